// File: rtl/fix_c_acc.sv
// fix_c_acc: complex accumulate-and-dump stage behind the fixed-point complex
// multiplier. Sums acc_len valid samples per frame, then applies an arithmetic
// right shift and saturates to OUT_WIDTH. Frames run back-to-back.
// A frame result is presented on a valid/ready output. The input side has no
// backpressure.
// Optional feature macro: FIX_C_ACC_ROUND_EN (round half up before the shift).
module fix_c_acc #(
  parameter int IN_WIDTH    = 16,
  parameter int OUT_WIDTH   = 16,
  parameter int MAX_LEN     = 256,
  parameter int SHIFT_MODE  = 1,
  parameter int SHIFT_CONST = 3
) (
  input  logic                                                 clk,
  input  logic                                                 rst,
  input  logic                                                 start,
  input  logic [$clog2(MAX_LEN+1)-1:0]                         acc_len,
  input  logic [$clog2(IN_WIDTH+$clog2(MAX_LEN)+1+1)-1:0]      shift_amount,
  input  logic signed [IN_WIDTH-1:0]                           in_R,
  input  logic signed [IN_WIDTH-1:0]                           in_I,
  input  logic                                                 in_valid,
  output logic signed [OUT_WIDTH-1:0]                          out_R,
  output logic signed [OUT_WIDTH-1:0]                          out_I,
  output logic                                                 out_valid,
  input  logic                                                 out_ready,
  output logic                                                 busy,
  output logic                                                 overrun
);

  localparam int ACC_WIDTH = IN_WIDTH + $clog2(MAX_LEN) + 1;
  localparam int LEN_W     = $clog2(MAX_LEN + 1);
  localparam int SH_W      = $clog2(ACC_WIDTH + 1);

  // Saturation bounds expressed in the widened (ACC_WIDTH+1) domain.
  localparam logic signed [ACC_WIDTH:0] SAT_MAX = (ACC_WIDTH+1)'((2 ** (OUT_WIDTH - 1)) - 1);
  localparam logic signed [ACC_WIDTH:0] SAT_MIN = ~SAT_MAX;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  // Zero or oversize lengths select a full MAX_LEN frame.
  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    if ((len == {LEN_W{1'b0}}) || (len > LEN_W'(MAX_LEN))) begin
      clamp_len = LEN_W'(MAX_LEN);
    end else begin
      clamp_len = len;
    end
  endfunction

  // Shifting by ACC_WIDTH-1 already leaves only the sign, so limit there.
  function automatic logic [SH_W-1:0] clamp_sh(input logic [SH_W-1:0] sh);
    if (sh > SH_W'(ACC_WIDTH - 1)) begin
      clamp_sh = SH_W'(ACC_WIDTH - 1);
    end else begin
      clamp_sh = sh;
    end
  endfunction

  // Scale one frame sum: optional round-half-up, arithmetic shift, saturate.
  function automatic logic signed [OUT_WIDTH-1:0] scale_sat(
    input logic signed [ACC_WIDTH-1:0] val,
    input logic        [SH_W-1:0]      sh
  );
    logic signed [ACC_WIDTH:0] ext;
    logic signed [ACC_WIDTH:0] shd;
    ext = {val[ACC_WIDTH-1], val};
`ifdef FIX_C_ACC_ROUND_EN
    if (sh != {SH_W{1'b0}}) begin
      ext = ext + $signed((ACC_WIDTH+1)'(1) << (sh - SH_W'(1)));
    end else begin
      ext = ext;
    end
`endif
    shd = ext >>> sh;
    if (shd > SAT_MAX) begin
      scale_sat = SAT_MAX[OUT_WIDTH-1:0];
    end else if (shd < SAT_MIN) begin
      scale_sat = SAT_MIN[OUT_WIDTH-1:0];
    end else begin
      scale_sat = shd[OUT_WIDTH-1:0];
    end
  endfunction

  state_t                        r_state;
  state_t                        w_state_nxt;
  logic [LEN_W-1:0]              r_len;
  logic [SH_W-1:0]               r_sh;
  logic [LEN_W-1:0]              r_cnt;
  logic signed [ACC_WIDTH-1:0]   r_acc_r;
  logic signed [ACC_WIDTH-1:0]   r_acc_i;
  logic signed [ACC_WIDTH-1:0]   r_dump_r;
  logic signed [ACC_WIDTH-1:0]   r_dump_i;
  logic [SH_W-1:0]               r_dump_sh;
  logic                          r_dump_vld;

  logic [SH_W-1:0]               w_sh_src;
  logic [LEN_W-1:0]              w_cur_len;
  logic [SH_W-1:0]               w_cur_sh;
  logic [LEN_W-1:0]              w_base_cnt;
  logic [LEN_W-1:0]              w_cnt_inc;
  logic signed [ACC_WIDTH-1:0]   w_base_r;
  logic signed [ACC_WIDTH-1:0]   w_base_i;
  logic signed [ACC_WIDTH-1:0]   w_in_r_ext;
  logic signed [ACC_WIDTH-1:0]   w_in_i_ext;
  logic signed [ACC_WIDTH-1:0]   w_sum_r;
  logic signed [ACC_WIDTH-1:0]   w_sum_i;
  logic                          w_take;
  logic                          w_last;
  logic signed [OUT_WIDTH-1:0]   w_res_r;
  logic signed [OUT_WIDTH-1:0]   w_res_i;

  assign w_sh_src = (SHIFT_MODE == 0) ? SH_W'(SHIFT_CONST) : shift_amount;

  // Next-state logic: start leaves IDLE; RUN persists until reset.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_state_nxt = S_RUN;
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RUN:   w_state_nxt = S_RUN;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Accumulate datapath: a start restarts the frame and a same-cycle sample is its first.
  always_comb begin
    w_cur_len  = r_len;
    w_cur_sh   = r_sh;
    w_base_cnt = r_cnt;
    w_base_r   = r_acc_r;
    w_base_i   = r_acc_i;
    if (start) begin
      w_cur_len  = clamp_len(acc_len);
      w_cur_sh   = clamp_sh(w_sh_src);
      w_base_cnt = {LEN_W{1'b0}};
      w_base_r   = {ACC_WIDTH{1'b0}};
      w_base_i   = {ACC_WIDTH{1'b0}};
    end else begin
      w_cur_len  = r_len;
      w_cur_sh   = r_sh;
    end
    w_in_r_ext = {{(ACC_WIDTH-IN_WIDTH){in_R[IN_WIDTH-1]}}, in_R};
    w_in_i_ext = {{(ACC_WIDTH-IN_WIDTH){in_I[IN_WIDTH-1]}}, in_I};
    w_sum_r    = w_base_r + w_in_r_ext;
    w_sum_i    = w_base_i + w_in_i_ext;
    w_cnt_inc  = w_base_cnt + LEN_W'(1);
    w_take     = in_valid & (start | (r_state == S_RUN));
    w_last     = w_take & (w_cnt_inc == w_cur_len);
  end

  // Scaled result of the frame held in the dump register.
  always_comb begin
    w_res_r = scale_sat(r_dump_r, r_dump_sh);
    w_res_i = scale_sat(r_dump_i, r_dump_sh);
  end

  // State, configuration, accumulator and dump register updates.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= S_IDLE;
      busy       <= 1'b0;
      r_len      <= {LEN_W{1'b0}};
      r_sh       <= {SH_W{1'b0}};
      r_cnt      <= {LEN_W{1'b0}};
      r_acc_r    <= {ACC_WIDTH{1'b0}};
      r_acc_i    <= {ACC_WIDTH{1'b0}};
      r_dump_r   <= {ACC_WIDTH{1'b0}};
      r_dump_i   <= {ACC_WIDTH{1'b0}};
      r_dump_sh  <= {SH_W{1'b0}};
      r_dump_vld <= 1'b0;
    end else begin
      r_state    <= w_state_nxt;
      busy       <= (w_state_nxt == S_RUN);
      r_len      <= w_cur_len;
      r_sh       <= w_cur_sh;
      r_dump_vld <= w_last;
      if (w_last) begin
        r_dump_r  <= w_sum_r;
        r_dump_i  <= w_sum_i;
        r_dump_sh <= w_cur_sh;
        r_acc_r   <= {ACC_WIDTH{1'b0}};
        r_acc_i   <= {ACC_WIDTH{1'b0}};
        r_cnt     <= {LEN_W{1'b0}};
      end else if (w_take) begin
        r_acc_r   <= w_sum_r;
        r_acc_i   <= w_sum_i;
        r_cnt     <= w_cnt_inc;
      end else begin
        r_acc_r   <= w_base_r;
        r_acc_i   <= w_base_i;
        r_cnt     <= w_base_cnt;
      end
    end
  end

  // Output register with valid/ready handshake and sticky overrun flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_R     <= {OUT_WIDTH{1'b0}};
      out_I     <= {OUT_WIDTH{1'b0}};
      out_valid <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      if (r_dump_vld) begin
        out_R     <= w_res_r;
        out_I     <= w_res_i;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
      // A lost result is reported even if start arrives in the same cycle.
      if (r_dump_vld && out_valid && !out_ready) begin
        overrun <= 1'b1;
      end else if (start) begin
        overrun <= 1'b0;
      end
    end
  end

endmodule

// File: doc/fix_c_acc.md
Name: fix_c_acc

Overview:
- Complex accumulate-and-dump stage directly downstream of the fix point complex multiplier; consumes its out_R/out_I product stream.
- Sums a programmable number of consecutive valid complex samples (correlation / dot-product frames), then scales by arithmetic right shift, saturates and presents one result per frame.
- Runs continuously, frame after frame, with no bubble between frames. Output side is valid/ready; input side is valid-only because the multiplier pipeline has no backpressure.

Parameters:
- IN_WIDTH, 16, signed width of in_R/in_I.
- OUT_WIDTH, 16, signed width of out_R/out_I.
- MAX_LEN, 256, maximum samples per frame.
- SHIFT_MODE, 1, 0 = shift by SHIFT_CONST, 1 = shift by runtime shift_amount.
- SHIFT_CONST, 3, fixed shift used when SHIFT_MODE = 0.
- Derived localparam ACC_WIDTH = IN_WIDTH + $clog2(MAX_LEN) + 1. The accumulator never wraps.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset; synchronous, active-high.
- start  input  1  pulse; arms or re-arms a frame and samples acc_len and shift_amount.
- acc_len  input  $clog2(MAX_LEN+1)  samples per frame.
- shift_amount  input  $clog2(ACC_WIDTH+1)  right-shift applied at dump.
- in_R, in_I  input  IN_WIDTH each  signed sample.
- in_valid  input  1  sample qualifier.
- out_R, out_I  output  OUT_WIDTH each  scaled, saturated frame sum.
- out_valid  output  1  result held until accepted.
- out_ready  input  1  consumer accepts the result.
- busy  output  1  high in RUN state.
- overrun  output  1  sticky; an unaccepted result was overwritten.

Behaviour:
- Reset:
  - State goes to IDLE. Accumulator, sample counter, dump register and out_R/out_I all go to 0.
  - out_valid, busy and overrun go to 0.
  - Reset mid-frame discards the partial sum and any pending result.
- States IDLE and RUN:
  - IDLE: in_valid is ignored.
  - start moves to RUN, with the accumulator and counter cleared.
  - In RUN, a further start aborts the partial frame, clears the accumulator and counter, and re-samples the configuration. A sample arriving in the same cycle as start is the first sample of the new frame.
- Configuration:
  - len = acc_len, latched at start.
  - acc_len = 0 or acc_len > MAX_LEN is clamped to MAX_LEN.
  - shift_amount is latched at start.
  - A shift > ACC_WIDTH-1 is clamped to ACC_WIDTH-1.
- Accumulation:
  - Each in_valid in RUN sign-extends the sample and adds it to acc_R/acc_I; the counter increments.
  - On the len-th valid sample, acc + sample is written to the dump register. The accumulator and counter are cleared in the same cycle, so the next cycle's sample starts the next frame with no gap.
- Dump, one cycle after the dump-register load:
  - dump >>> shift (arithmetic, floor), then saturate to [-2^(OUT_WIDTH-1), 2^(OUT_WIDTH-1)-1].
  - Result is loaded into out_R/out_I and out_valid is set.
- Latency: final sample at cycle T gives out_valid high at T+2.
- Output handshake:
  - The transfer happens when out_valid & out_ready.
  - out_valid clears after a transfer unless a new result loads in the same cycle.
  - A new result loads while out_valid & !out_ready: the old result is overwritten and overrun is set.
  - A new result loads in the same cycle as a transfer: no overrun.
  - overrun clears only on rst or start.
- Back-to-back frames with len = 1 produce one result per valid cycle.

Optional Feature:
- Macro FIX_C_ACC_ROUND_EN.
- Defined: before the shift, add 2^(shift-1) when shift > 0 (round half up), then saturate. The add is done in ACC_WIDTH+1 bits so it cannot wrap.
- Undefined: truncating shift (floor) only.
- Latency is unchanged either way.

Test Plan:
- Basic sum: start, acc_len = 4, shift = 0, out_ready = 1; inputs (1,-1), (2,-2), (3,-3), (4,-4) on consecutive cycles -> out = (10,-10), out_valid for 1 cycle, 2 cycles after the last input.
- Saturation and shift: acc_len = 4, four samples of (32767,-32768).
  - shift = 0 -> (32767,-32768) saturated.
  - shift = 2 -> (32767,-32768) exact.
  - shift = 3 -> (16383,-16384).
- Rounding: acc_len = 1, sample (7,-7), shift = 1.
  - Macro undefined -> (3,-4).
  - Macro defined -> (4,-3).
- Continuous and overrun: acc_len = 2, out_ready = 0, samples 1..6 back-to-back.
  - Results at 3, 7, 11, each overwriting the last.
  - out = (11,·), overrun = 1.
  - out_ready pulses once -> out_valid falls; overrun stays 1 until start.
- Abort: acc_len = 4, send 2 samples of (5,5), pulse start, send four samples of (1,1) -> single result (4,4) only.
- Reset mid-frame: 3 of 4 samples sent, assert rst for 1 cycle -> all outputs 0 and IDLE; subsequent in_valid is ignored until start.
